sobel_frame_sequencer: RTL and testbench
========================================

Name: sobel_frame_sequencer

Overview:
- Frame-level controller placed between the SPI pixel interface and the gray/sobel datapath core.
- Latches the processing mode at frame start and strobes each accepted pixel into the core.
- After the last real pixel, injects zero flush pixels to drain the core's window and pipeline latency.
- Counts returned pixels through a 1-entry output buffer, and reports frame done, timeout and overrun.

Parameters:
- PIXEL_WIDTH, 8, bits per pixel.
- IMG_W, 16, pixels per row.
- IMG_H, 16, rows per frame.
- FLUSH_MAX, 64, maximum flush pixels injected before timeout.
- CNT_W, 16, width of the pixel counters. Must satisfy 2^CNT_W > IMG_W*IMG_H + FLUSH_MAX.

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous, active-high reset.
- cfg_select_i, in, 2: mode request (00 bypass, 01 gray, 10 sobel, 11 gray+sobel).
- frame_start_i, in, 1: start-of-frame pulse.
- in_px_valid_i, in, 1: input pixel valid.
- in_px_i, in, PIXEL_WIDTH: input pixel.
- in_px_ready_o, out, 1: sequencer accepts the input pixel.
- core_start_o, out, 1: one-cycle strobe presenting core_px_o to the core.
- core_select_o, out, 2: latched mode to the core.
- core_px_o, out, PIXEL_WIDTH: pixel to the core.
- core_px_ready_i, in, 1: core output pixel valid (one cycle).
- core_px_i, in, PIXEL_WIDTH: core output pixel.
- out_px_valid_o, out, 1: output buffer full.
- out_px_o, out, PIXEL_WIDTH: buffered output pixel.
- out_px_ready_i, in, 1: consumer pops the buffer.
- busy_o, out, 1: FEED or FLUSH.
- frame_done_o, out, 1: one-cycle pulse at frame end.
- timeout_o, out, 1: sticky flag; flush exhausted before all outputs returned.
- overrun_o, out, 1: sticky flag; core output arrived while the buffer was full.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk_i.
  - reset_i high: state=IDLE, all counters 0, buffer empty.
  - Every output is 0 during and after reset, including core_select_o and both sticky flags.
  - Reset mid-frame aborts the frame immediately; no frame_done_o pulse.
- Counters:
  - N = IMG_W*IMG_H.
  - in_cnt: pixels strobed to the core, including flush pixels.
  - out_cnt: core outputs captured.
  - flush_cnt: flush pixels injected.
- IDLE:
  - in_px_ready_o=0, busy_o=0.
  - frame_start_i=1: latch cfg_select_i into core_select_o; clear in_cnt, out_cnt, flush_cnt, timeout_o and overrun_o; go to FEED next cycle.
- FEED:
  - in_px_ready_o=1.
  - Each cycle with in_px_valid_i & in_px_ready_o: register in_px_i to core_px_o and assert core_start_o for exactly one cycle (1-cycle latency); in_cnt+1.
  - When the N-th pixel is accepted, in_px_ready_o drops in the following cycle and the state goes to FLUSH.
- FLUSH:
  - in_px_ready_o=0.
  - Each cycle with out_cnt<N and flush_cnt<FLUSH_MAX: core_start_o=1, core_px_o=0, flush_cnt+1.
  - Injection stops in the cycle after out_cnt reaches N.
  - out_cnt==N: go to DONE.
  - flush_cnt==FLUSH_MAX and out_cnt<N: set timeout_o, go to DONE.
- DONE: frame_done_o=1 for one cycle, then IDLE.
- Output capture (all states except reset):
  - core_px_ready_i & buffer empty (or popped in the same cycle): load core_px_i, out_px_valid_o=1.
  - Outputs are counted only while out_cnt<N; surplus outputs after N are discarded and do not set overrun_o.
  - core_px_ready_i while full and out_px_ready_i=0: keep the old pixel, drop the new one, set overrun_o, out_cnt still +1.
  - Pop (out_px_valid_o & out_px_ready_i) without a new load: buffer empty next cycle.
- frame_start_i outside IDLE is ignored; cfg_select_i changes mid-frame have no effect.
- busy_o=1 exactly in FEED and FLUSH.
- Counters do not wrap: the CNT_W constraint guarantees it.

Test Plan:
- Nominal frame:
  - Stimulus: IMG_W=IMG_H=4, core model with 5-cycle latency, cfg 10, continuous valid, out_px_ready_i=1.
  - Required: 16 core_start_o pulses with data; 5 zero flush pulses; 16 outputs; frame_done_o one cycle after the 16th capture; core_select_o=10; timeout_o=0, overrun_o=0.
- Input gaps:
  - Stimulus: in_px_valid_i toggling 1010..., pixel values 0..15.
  - Required: core_px_o sequence 0..15 in order; core_start_o pulses only one cycle after accepted pixels.
- Backpressure overrun:
  - Stimulus: out_px_ready_i=0 throughout a frame.
  - Required: buffer keeps the first output value; overrun_o=1 from the 2nd output onward; frame still completes (out_cnt=16).
- Timeout:
  - Stimulus: core model never asserts core_px_ready_i, FLUSH_MAX=8.
  - Required: exactly 8 flush strobes; timeout_o=1; frame_done_o pulses; return to IDLE.
- Ignored start:
  - Stimulus: frame_start_i with cfg 01 mid-FEED.
  - Required: ignored; core_select_o unchanged. Next frame_start_i in IDLE clears both sticky flags.
- Reset mid-frame:
  - Stimulus: reset_i high during FLUSH.
  - Required: next cycle all outputs 0, state IDLE, no frame_done_o; a new frame then runs normally.

Source files
------------

// File: rtl/sobel_frame_sequencer.sv
// Frame sequencer between the SPI pixel port and the gray/sobel core: feeds pixels (1-cycle latency),
// drains the core with zero flush pixels, and buffers results in one entry (full + no pop = drop, flag overrun).
module sobel_frame_sequencer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_W       = 16,
    parameter int IMG_H       = 16,
    parameter int FLUSH_MAX   = 64,
    parameter int CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [1:0]             cfg_select_i,
    input  logic                   frame_start_i,
    input  logic                   in_px_valid_i,
    input  logic [PIXEL_WIDTH-1:0] in_px_i,
    output logic                   in_px_ready_o,
    output logic                   core_start_o,
    output logic [1:0]             core_select_o,
    output logic [PIXEL_WIDTH-1:0] core_px_o,
    input  logic                   core_px_ready_i,
    input  logic [PIXEL_WIDTH-1:0] core_px_i,
    output logic                   out_px_valid_o,
    output logic [PIXEL_WIDTH-1:0] out_px_o,
    input  logic                   out_px_ready_i,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   timeout_o,
    output logic                   overrun_o
);

    localparam logic [CNT_W-1:0] NUM_PX    = CNT_W'(IMG_W * IMG_H);
    localparam logic [CNT_W-1:0] FLUSH_LIM = CNT_W'(FLUSH_MAX);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FEED  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [1:0]             select_q, select_d;
    logic                   start_q, start_d;
    logic [PIXEL_WIDTH-1:0] core_px_q, core_px_d;
    logic [CNT_W-1:0]       in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]       out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic                   buf_vld_q, buf_vld_d;
    logic [PIXEL_WIDTH-1:0] buf_px_q, buf_px_d;
    logic                   timeout_q, timeout_d;
    logic                   overrun_q, overrun_d;
    logic                   capture;

    always_comb begin
        state_d     = state_q;
        select_d    = select_q;
        start_d     = 1'b0;
        core_px_d   = core_px_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        flush_cnt_d = flush_cnt_q;
        buf_vld_d   = buf_vld_q;
        buf_px_d    = buf_px_q;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;

        // Outputs beyond the frame's pixel count are flush residue and are dropped silently.
        capture = core_px_ready_i && (out_cnt_q < NUM_PX);
        if (capture) begin
            out_cnt_d = out_cnt_q + ONE;
            if (!buf_vld_q || out_px_ready_i) begin
                buf_vld_d = 1'b1;
                buf_px_d  = core_px_i;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (buf_vld_q && out_px_ready_i) begin
            buf_vld_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                if (frame_start_i) begin
                    select_d    = cfg_select_i;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    flush_cnt_d = '0;
                    timeout_d   = 1'b0;
                    overrun_d   = 1'b0;
                    state_d     = S_FEED;
                end
            end
            S_FEED: begin
                if (in_px_valid_i) begin
                    start_d   = 1'b1;
                    core_px_d = in_px_i;
                    in_cnt_d  = in_cnt_q + ONE;
                    if (in_cnt_q == NUM_PX - ONE) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                // Look at this cycle's capture so no flush pixel follows the last real output.
                if (out_cnt_d == NUM_PX) begin
                    state_d = S_DONE;
                end else if (flush_cnt_q == FLUSH_LIM) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    start_d     = 1'b1;
                    core_px_d   = '0;
                    in_cnt_d    = in_cnt_q + ONE;
                    flush_cnt_d = flush_cnt_q + ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            select_q    <= '0;
            start_q     <= 1'b0;
            core_px_q   <= '0;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            flush_cnt_q <= '0;
            buf_vld_q   <= 1'b0;
            buf_px_q    <= '0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            select_q    <= select_d;
            start_q     <= start_d;
            core_px_q   <= core_px_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            buf_vld_q   <= buf_vld_d;
            buf_px_q    <= buf_px_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign in_px_ready_o  = (state_q == S_FEED);
    assign busy_o         = (state_q == S_FEED) || (state_q == S_FLUSH);
    assign frame_done_o   = (state_q == S_DONE);
    assign core_start_o   = start_q;
    assign core_select_o  = select_q;
    assign core_px_o      = core_px_q;
    assign out_px_valid_o = buf_vld_q;
    assign out_px_o       = buf_px_q;
    assign timeout_o      = timeout_q;
    assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Frame-level bench: scenario table plus random frames against a latency-line core model and a scoreboard.
module tb_sobel_frame_sequencer;

    localparam int PW   = 8;
    localparam int NPX  = 16;
    localparam int FMAX = 8;
    localparam int LAT  = 5;

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [1:0]    cfg_select_i;
    logic          frame_start_i;
    logic          in_px_valid_i;
    logic [PW-1:0] in_px_i;
    logic          in_px_ready_o;
    logic          core_start_o;
    logic [1:0]    core_select_o;
    logic [PW-1:0] core_px_o;
    logic          core_px_ready_i;
    logic [PW-1:0] core_px_i;
    logic          out_px_valid_o;
    logic [PW-1:0] out_px_o;
    logic          out_px_ready_i;
    logic          busy_o;
    logic          frame_done_o;
    logic          timeout_o;
    logic          overrun_o;

    sobel_frame_sequencer #(
        .PIXEL_WIDTH(PW), .IMG_W(4), .IMG_H(4), .FLUSH_MAX(FMAX), .CNT_W(16)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cfg_select_i(cfg_select_i),
        .frame_start_i(frame_start_i), .in_px_valid_i(in_px_valid_i), .in_px_i(in_px_i),
        .in_px_ready_o(in_px_ready_o), .core_start_o(core_start_o),
        .core_select_o(core_select_o), .core_px_o(core_px_o),
        .core_px_ready_i(core_px_ready_i), .core_px_i(core_px_i),
        .out_px_valid_o(out_px_valid_o), .out_px_o(out_px_o),
        .out_px_ready_i(out_px_ready_i), .busy_o(busy_o), .frame_done_o(frame_done_o),
        .timeout_o(timeout_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] cfg;
        int         gap;      // 0 continuous, 1 alternating, 2 random
        bit         px_seq;   // pixel values 0..15 instead of random
        bit         out_rdy;
        bit         core_en;
        bit         glitch;   // extra frame_start with cfg 01 mid-feed
        int         exp_flush;
        int         exp_pops;
        bit         exp_to;
        bit         exp_ovr;
    } scen_t;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [LAT-1:0] pipe;
    logic [PW-1:0]  pdat [LAT];
    bit             core_en;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [24:0] outs();
        return {in_px_ready_o, core_start_o, core_select_o, core_px_o, out_px_valid_o,
                out_px_o, busy_o, frame_done_o, timeout_o, overrun_o};
    endfunction

    // Core model: every strobe returns (pixel ^ A5) LAT cycles later; reset empties it.
    task automatic tick();
        logic          st;
        logic [PW-1:0] px;
        st = core_start_o;
        px = core_px_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (reset_i) begin
            pipe = '0;
        end else begin
            pipe = {pipe[LAT-2:0], st};
            for (int i = LAT - 1; i > 0; i--) pdat[i] = pdat[i-1];
            pdat[0] = px ^ 8'hA5;
        end
        core_px_ready_i = core_en && pipe[LAT-1];
        core_px_i       = pdat[LAT-1];
    endtask

    task automatic run_frame(input scen_t s, input string tag);
        logic [PW-1:0] px_list [NPX];
        int idx = 0, nstrobe = 0, nflush = 0, npop = 0, nrdy = 0;
        int done_cyc = -1, nth_rdy_cyc = -100, last_st_cyc = -100, extra_done = 0;
        int align_err = 0, data_err = 0, pop_err = 0, sel_err = 0, ovr_err = 0;
        bit prev_acc = 0, seen_done = 0, glitched = 0, v, exp_ovr;
        logic [PW-1:0] prev_px = '0;

        for (int i = 0; i < NPX; i++) px_list[i] = s.px_seq ? PW'(i) : PW'($urandom);
        core_en        = s.core_en;
        out_px_ready_i = s.out_rdy;
        cfg_select_i   = s.cfg;
        frame_start_i  = 1'b1;
        tick();
        frame_start_i  = 1'b0;
        check({tag, "_flags_cleared"}, {timeout_o, overrun_o}, 0);
        check({tag, "_busy"}, busy_o, 1);

        for (int t = 0; t < 200 && !seen_done; t++) begin
            case (s.gap)
                0:       v = 1'b1;
                1:       v = (t % 2 == 0);
                default: v = ($urandom_range(0, 2) != 0);
            endcase
            in_px_valid_i = v && (idx < NPX);
            in_px_i       = in_px_valid_i ? px_list[idx] : PW'($urandom);
            if (s.glitch && idx == 5 && !glitched) begin
                frame_start_i = 1'b1;
                cfg_select_i  = 2'b01;
                glitched      = 1'b1;
            end else begin
                frame_start_i = 1'b0;
                cfg_select_i  = 2'($urandom);
            end

            exp_ovr = !s.out_rdy && (nrdy >= 2);
            if (overrun_o != exp_ovr) ovr_err++;
            if (core_px_ready_i && nrdy < NPX) begin
                nrdy++;
                if (nrdy == NPX) nth_rdy_cyc = cyc;
            end
            if (core_start_o) begin
                if (nstrobe < NPX) begin
                    if (!prev_acc || core_px_o != prev_px) align_err++;
                    if (core_px_o != px_list[nstrobe]) data_err++;
                end else begin
                    nflush++;
                    if (prev_acc || core_px_o != 0) align_err++;
                end
                nstrobe++;
                last_st_cyc = cyc;
            end else if (prev_acc) begin
                align_err++;
            end
            if (out_px_valid_o && out_px_ready_i) begin
                if (npop >= NPX || out_px_o != (px_list[npop] ^ 8'hA5)) pop_err++;
                npop++;
            end
            if (core_select_o != s.cfg) sel_err++;
            if (frame_done_o) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                check({tag, "_timeout_at_done"}, timeout_o, s.exp_to);
                check({tag, "_overrun_at_done"}, overrun_o, s.exp_ovr);
            end
            prev_acc = in_px_valid_i && in_px_ready_o;
            prev_px  = in_px_i;
            if (prev_acc) idx++;
            tick();
        end
        frame_start_i = 1'b0;
        in_px_valid_i = 1'b0;

        check({tag, "_done_seen"}, seen_done, 1);
        check({tag, "_pixels_consumed"}, idx, NPX);
        check({tag, "_data_order_errs"}, data_err, 0);
        check({tag, "_strobe_align_errs"}, align_err, 0);
        check({tag, "_flush_pulses"}, nflush, s.exp_flush);
        check({tag, "_pops"}, npop, s.exp_pops);
        check({tag, "_pop_data_errs"}, pop_err, 0);
        check({tag, "_select_errs"}, sel_err, 0);
        check({tag, "_overrun_trace_errs"}, ovr_err, 0);
        if (s.core_en) check({tag, "_done_after_last_capture"}, done_cyc - nth_rdy_cyc, 1);
        else           check({tag, "_done_after_last_flush"}, done_cyc - last_st_cyc, 1);
        if (!s.out_rdy) begin
            check({tag, "_buf_held_valid"}, out_px_valid_o, 1);
            check({tag, "_buf_held_first"}, out_px_o, px_list[0] ^ 8'hA5);
        end

        // Drain: empty the buffer, let surplus core outputs arrive in IDLE, check nothing else fires.
        out_px_ready_i = 1'b1;
        for (int t = 0; t < 20 && (t < 3 || pipe != 0); t++) begin
            if (frame_done_o) extra_done++;
            tick();
        end
        check({tag, "_single_done_pulse"}, extra_done, 0);
        check({tag, "_idle_after"}, {busy_o, in_px_ready_o, out_px_valid_o}, 0);
        check({tag, "_timeout_sticky"}, timeout_o, s.exp_to);
    endtask

    scen_t tbl [5];
    scen_t rs;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_in_reset = 0;
        //        cfg    gap px_seq rdy en glitch flush pops to ovr
        tbl[0] = '{2'b10, 0, 1'b1, 1'b1, 1'b1, 1'b0, LAT,  NPX, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 1, 1'b1, 1'b1, 1'b1, 1'b0, LAT,  NPX, 1'b0, 1'b0};
        tbl[2] = '{2'b01, 0, 1'b0, 1'b0, 1'b1, 1'b0, LAT,  0,   1'b0, 1'b1};
        tbl[3] = '{2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0, FMAX, 0,   1'b1, 1'b0};
        tbl[4] = '{2'b10, 2, 1'b0, 1'b1, 1'b1, 1'b1, LAT,  NPX, 1'b0, 1'b0};

        reset_i = 1'b1; cfg_select_i = 2'b11; frame_start_i = 1'b0;
        in_px_valid_i = 1'b0; in_px_i = '0; core_px_ready_i = 1'b0; core_px_i = '0;
        out_px_ready_i = 1'b0; core_en = 1'b0; pipe = '0;
        for (int i = 0; i < LAT; i++) pdat[i] = '0;

        for (int i = 0; i < 3; i++) tick();
        check("reset_outputs", int'(outs()), 0);
        reset_i = 1'b0;
        tick();
        check("post_reset_outputs", int'(outs()), 0);

        for (int i = 0; i < 5; i++) run_frame(tbl[i], $sformatf("row%0d", i));

        for (int i = 0; i < 4; i++) begin
            rs = '{2'($urandom), 2, 1'b0, 1'b1, 1'b1, 1'b0, LAT, NPX, 1'b0, 1'b0};
            run_frame(rs, $sformatf("rand%0d", i));
        end

        // Reset while flushing: frame aborts with no done pulse, then a clean frame follows.
        core_en = 1'b1; out_px_ready_i = 1'b1;
        cfg_select_i = 2'b11; frame_start_i = 1'b1;
        tick();
        frame_start_i = 1'b0;
        in_px_valid_i = 1'b1;
        for (int t = 0; t < 40 && !(busy_o && !in_px_ready_o); t++) begin
            in_px_i = PW'($urandom);
            tick();
        end
        in_px_valid_i = 1'b0;
        check("rst_reached_flush", {busy_o, in_px_ready_o}, 2'b10);
        tick();
        tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("rst_abort_outputs", int'(outs()), 0);
        for (int t = 0; t < 8; t++) begin
            if (frame_done_o) done_in_reset++;
            tick();
        end
        check("rst_no_done_pulse", done_in_reset, 0);
        check("rst_idle_outputs", int'(outs()), 0);
        run_frame(tbl[0], "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
